// File: rtl/i2s_sample_fifo.sv
// First-word-fall-through stereo sample FIFO between the audio register file and the I2S serializer.
// Provides level/threshold status, sticky overflow/underrun flags and a synchronous software flush.
module i2s_sample_fifo #(
  parameter int FIFO_LEN_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [47:0]              wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [FIFO_LEN_BITS:0]   fifo_threshold,
  output logic [FIFO_LEN_BITS:0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_low,
  output logic [47:0]              rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     overflow,
  output logic                     underrun
);

  localparam int DEPTH = 1 << FIFO_LEN_BITS;
  localparam int PW    = FIFO_LEN_BITS + 1;
  localparam logic [PW-1:0] DEPTH_LVL    = PW'(DEPTH);
  localparam logic [PW-1:0] DEPTH_M1_LVL = PW'(DEPTH - 1);

  logic [47:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable by subtraction.
  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_level == DEPTH_LVL);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_low   = (fifo_level < fifo_threshold);

  // One slot of margin: the producer's write strobe lags its sampling of wr_ready by a cycle.
  assign wr_ready = (fifo_level < DEPTH_M1_LVL) && !flush && !rst;
  assign rd_valid = !fifo_empty && !flush;
  assign rd_data  = mem[rd_ptr[FIFO_LEN_BITS-1:0]];

  assign push = wr_valid && !fifo_full && !flush;
  assign pop  = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_LEN_BITS-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_valid && fifo_full) begin
        overflow <= 1'b1;
      end
      if (rd_ready && fifo_empty) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Self-checking bench for i2s_sample_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_i2s_sample_fifo;

  localparam int FLB   = 4;
  localparam int DEPTH = 1 << FLB;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [47:0]     wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [FLB:0]    fifo_threshold;
  logic [FLB:0]    fifo_level;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_low;
  logic [47:0]     rd_data;
  logic            rd_valid;
  logic            rd_ready;
  logic            overflow;
  logic            underrun;

  i2s_sample_fifo #(.FIFO_LEN_BITS(FLB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .fifo_threshold(fifo_threshold), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_low(fifo_low),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO contents as a plain queue plus the two sticky flags.
  logic [47:0] model_q [$];
  logic        model_ovf;
  logic        model_und;
  int          checks;
  int          errors;
  logic        seen_wr_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int n;
    n = model_q.size();
    check("level",    64'(fifo_level), 64'(n));
    check("empty",    64'(fifo_empty), 64'(n == 0));
    check("full",     64'(fifo_full),  64'(n == DEPTH));
    check("low",      64'(fifo_low),   64'(n < int'(fifo_threshold)));
    check("rd_valid", 64'(rd_valid),   64'((n > 0) && !flush));
    check("wr_ready", 64'(wr_ready),   64'((n < DEPTH - 1) && !flush && !rst));
    check("overflow", 64'(overflow),   64'(model_ovf));
    check("underrun", 64'(underrun),   64'(model_und));
    if ((n > 0) && !flush) begin
      check("rd_data", 64'(rd_data), 64'(model_q[0]));
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input logic rs, input logic fl, input logic wv,
                               input logic [47:0] wd, input logic rr);
    bit m_empty;
    bit m_full;
    rst      = rs;
    flush    = fl;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(negedge clk);
    checkOutput();
    seen_wr_ready = wr_ready;
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_und = 1'b0;
    end else begin
      m_empty = (model_q.size() == 0);
      m_full  = (model_q.size() == DEPTH);
      if (wv && m_full)  model_ovf = 1'b1;
      if (rr && m_empty) model_und = 1'b1;
      if (rr && !m_empty) void'(model_q.pop_front());
      if (wv && !m_full)  model_q.push_back(wd);
    end
    #1;
  endtask

  function automatic logic [47:0] sample_word(input int k);
    return {24'(k), 24'(k)};
  endfunction

  initial begin
    int pushed;
    int thr_list [3];
    logic [47:0] rnd;
    checks = 0;
    errors = 0;
    model_ovf = 1'b0;
    model_und = 1'b0;
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    fifo_threshold = 5'd4;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then first idle cycle after reset.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Producer that honours wr_ready one cycle late: 16 words fill the FIFO without overflow.
    pushed = 0;
    while (pushed < 16) begin
      if (seen_wr_ready) begin
        pushed++;
        applyStimulus(1'b0, 1'b0, 1'b1, sample_word(pushed), 1'b0);
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("filled_full", 64'(fifo_full), 64'(1));
    check("filled_no_ovf", 64'(overflow), 64'(0));

    // Drain all 16 in order.
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("drained_empty", 64'(fifo_empty), 64'(1));

    // Fill, force a write while full, then flush.
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b1, sample_word(100 + i), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 48'hDEAD_BEEF_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_level", 64'(fifo_level), 64'(16));
    applyStimulus(1'b0, 1'b1, 1'b1, 48'h1234, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("flush_level", 64'(fifo_level), 64'(0));
    check("flush_ovf", 64'(overflow), 64'(0));

    // Push and pop together on an empty FIFO: word kept, underrun raised.
    applyStimulus(1'b0, 1'b0, 1'b1, 48'hABCDEF_123456, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("und_set", 64'(underrun), 64'(1));
    check("und_data", 64'(rd_data), 64'(48'hABCDEF_123456));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);

    // Steady state at level 8 with simultaneous push/pop; pointers wrap several times.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, sample_word(200 + i), 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b1, sample_word(300 + i), 1'b1);
    check("steady_level", 64'(fifo_level), 64'(8));

    // Threshold sweep across every level 0..16.
    thr_list = '{0, 5, 16};
    foreach (thr_list[t]) begin
      fifo_threshold = 5'(thr_list[t]);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i <= 16; i++) applyStimulus(1'b0, 1'b0, (i < 16), sample_word(500 + i), 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Random traffic with occasional flush/reset and threshold changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) fifo_threshold = 5'($urandom_range(0, 16));
      rnd = {16'($urandom), 32'($urandom)};
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 9) < 6), rnd, ($urandom_range(0, 9) < 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_sample_fifo.md
# i2s_sample_fifo

Synchronous sample FIFO between the audio Wishbone register file and the I2S/DAC serializer. It buffers 48-bit stereo samples (`{right[23:0], left[23:0]}`) written by the register file and presents them first-word-fall-through to the serializer. It generates the ready, full, empty, low and level status the register file exposes to software. It also keeps sticky overflow/underrun flags and honours the software reset as a synchronous flush.

## Interface

- `FIFO_LEN_BITS`, 4, log2 of depth; DEPTH = 2^FIFO_LEN_BITS entries (default 16).

- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear; driven from software_rst (CTRL0 bit 0).
- `wr_data` in 48: sample from register file audio_data.
- `wr_valid` in 1: one-cycle write strobe (audio_valid).
- `wr_ready` out 1: fifo_ready to register file.
- `fifo_threshold` in FIFO_LEN_BITS+1: low-water threshold.
- `fifo_level` out FIFO_LEN_BITS+1: current entry count, 0..DEPTH.
- `fifo_full` out 1: level == DEPTH.
- `fifo_empty` out 1: level == 0.
- `fifo_low` out 1: level < fifo_threshold, unsigned compare.
- `rd_data` out 48: head entry; valid only while rd_valid.
- `rd_valid` out 1: head entry available.
- `rd_ready` in 1: serializer consumes head this cycle.
- `overflow` out 1: sticky; a write arrived while full.
- `underrun` out 1: sticky; rd_ready asserted while empty.

## Operation

- Storage: DEPTH x 48 array. Pointers `wr_ptr` and `rd_ptr` are each FIFO_LEN_BITS+1 bits and wrap modulo 2·DEPTH. Array index is the low FIFO_LEN_BITS bits. `fifo_level = wr_ptr - rd_ptr`, truncated to FIFO_LEN_BITS+1 bits.
- Push: when `wr_valid && !fifo_full && !flush`, store at wr_ptr and increment wr_ptr.
- Pop: when `rd_valid && rd_ready && !flush`, increment rd_ptr.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- `wr_ready = (fifo_level < DEPTH-1) && !flush && !rst`. The one-slot margin is required because the producer registers audio_valid one cycle after sampling wr_ready, so at most one write is in flight. Honouring wr_ready therefore never overflows.
- `rd_valid = !fifo_empty && !flush`. `rd_data = mem[rd_ptr]` (fall-through, combinational read of head).
- Write while full: data dropped, pointers unchanged, `overflow` set to 1.
- `rd_ready` while empty, including the empty-with-simultaneous-push case: no pop; the pushed word is stored and `underrun` set to 1.
- Flush, or rst: wr_ptr = rd_ptr = 0 and overflow = underrun = 0.
  - While flush is high, writes are ignored without setting overflow, and rd_ready is ignored without setting underrun.
  - Array contents are not cleared.
- Status outputs are combinational from registered pointers plus the fifo_threshold input; there is no internal FSM beyond the pointer/flag registers.

## Timing

- Reset values: fifo_level = 0, fifo_empty = 1, fifo_full = 0, rd_valid = 0, wr_ready = 0 during rst and 1 in the first cycle after, overflow = 0, underrun = 0.
- fifo_low after reset equals `0 < fifo_threshold`, so it is 0 when threshold = 0.
- Push accepted at edge n: fifo_level, fifo_empty and rd_valid reflect it in cycle n+1. Write-to-read latency is 1 cycle.
- Pop at edge n: the next head appears on rd_data in cycle n+1.
- wr_ready falls in the cycle after level reaches DEPTH-1 and rises in the cycle after level drops below DEPTH-1.
- Sustained throughput: one push and one pop per cycle.
- Flush or reset asserted mid-stream takes effect at the next edge. Any push or pop in that cycle is discarded.

## Test plan

- Reset, then threshold = 4 -> level 0, empty 1, full 0, low 1, wr_ready 1, rd_valid 0, flags 0.
- Push 0x000001_000001..0x000010_000010 as one write per cycle, gated by wr_ready through a one-cycle-delayed producer model:
  - wr_ready drops at level 15;
  - the in-flight write fills to 16; full = 1; overflow stays 0.
  - Then pop all 16 with rd_ready = 1 -> data returned in order, empty at end.
- Fill to 16, force an extra wr_valid -> level stays 16 and overflow = 1. Assert flush one cycle -> level 0, overflow 0, rd_valid 0.
- Empty FIFO, wr_valid and rd_ready in the same cycle -> level 1 next cycle, underrun = 1, word readable afterwards.
- Level 8, push and pop simultaneously for 100 cycles -> level constant 8, pointers wrap past 2·DEPTH, data order preserved.
- Threshold 0, 5 and 16 swept against levels 0..16 -> fifo_low = level < threshold in every cycle.
